// File: rtl/rat_ckpt.sv
// rtl/rat_ckpt.sv - register alias table with multi-slot rename, multi-port commit and FIFO branch checkpoints
// Lookups are combinational on the live table; renames, commits and checkpoint moves update on the clock edge.
module rat_ckpt #(
   parameter int NUM_ARCH = 32,
   parameter int TAG_W    = 5,
   parameter int RENAME_W = 2,
   parameter int COMMIT_W = 2,
   parameter int NUM_CKPT = 4,
   localparam int AW = $clog2(NUM_ARCH),
   localparam int CW = $clog2(NUM_CKPT),
   localparam int SW = (RENAME_W > 1) ? $clog2(RENAME_W) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [RENAME_W-1:0]       ren_valid,
   input  logic [RENAME_W*AW-1:0]    ren_dest,
   input  logic [RENAME_W*TAG_W-1:0] ren_tag,
   input  logic [RENAME_W*AW-1:0]    ren_rs,
   input  logic [RENAME_W*AW-1:0]    ren_rt,
   output logic [RENAME_W*TAG_W-1:0] rs_tag,
   output logic [RENAME_W*TAG_W-1:0] rt_tag,
   output logic [RENAME_W-1:0]       rs_alloc,
   output logic [RENAME_W-1:0]       rt_alloc,
   input  logic [COMMIT_W-1:0]       commit_valid,
   input  logic [COMMIT_W*AW-1:0]    commit_arch,
   input  logic [COMMIT_W*TAG_W-1:0] commit_tag,
   input  logic                      ckpt_save,
   input  logic [SW-1:0]             ckpt_slot,
   output logic [CW-1:0]             ckpt_id,
   output logic                      ckpt_full,
   input  logic                      ckpt_release,
   input  logic                      restore_valid,
   input  logic [CW-1:0]             restore_id,
   input  logic                      flush
);

   logic             r_al  [NUM_ARCH];
   logic [TAG_W-1:0] r_tg  [NUM_ARCH];
   logic             r_cal [NUM_CKPT][NUM_ARCH];
   logic [TAG_W-1:0] r_ctg [NUM_CKPT][NUM_ARCH];
   logic [CW-1:0]    r_head;
   logic [CW-1:0]    r_tail;
   logic [CW:0]      r_count;

   logic             w_nal  [NUM_ARCH];
   logic [TAG_W-1:0] w_ntg  [NUM_ARCH];
   logic             w_sal  [NUM_ARCH];
   logic [TAG_W-1:0] w_stg  [NUM_ARCH];
   logic             w_cal  [NUM_CKPT][NUM_ARCH];
   logic [TAG_W-1:0] w_ctg  [NUM_CKPT][NUM_ARCH];
   logic [AW-1:0]    w_src;
   logic             w_la;
   logic [TAG_W-1:0] w_lt;
   logic [CW-1:0]    w_rdist;
   logic             w_restore;
   logic             w_release;
   logic             w_save;

   // An entry retires only when the committing tag is still the one it holds; stale commits miss.
   function automatic logic f_hit(input logic [AW-1:0] a, input logic al, input logic [TAG_W-1:0] t,
                                  input logic [COMMIT_W-1:0] cv, input logic [COMMIT_W*AW-1:0] ca,
                                  input logic [COMMIT_W*TAG_W-1:0] ct);
      logic h;
      h = 1'b0;
      for (int c = 0; c < COMMIT_W; c++)
         if (al && cv[c] && ca[c*AW +: AW] == a && ct[c*TAG_W +: TAG_W] == t) h = 1'b1;
      return h;
   endfunction

   always_comb begin
      rs_tag   = '0;
      rt_tag   = '0;
      rs_alloc = '0;
      rt_alloc = '0;
      w_src    = '0;
      w_la     = 1'b0;
      w_lt     = '0;
      for (int k = 0; k < RENAME_W; k++) begin
         for (int p = 0; p < 2; p++) begin
            w_src = (p == 0) ? ren_rs[k*AW +: AW] : ren_rt[k*AW +: AW];
            w_la  = r_al[w_src];
            w_lt  = r_tg[w_src];
            if (f_hit(w_src, w_la, w_lt, commit_valid, commit_arch, commit_tag)) begin
               w_la = 1'b0;
               w_lt = '0;
            end
            for (int j = 0; j < k; j++)
               if (ren_valid[j] && ren_dest[j*AW +: AW] == w_src) begin
                  w_la = 1'b1;
                  w_lt = ren_tag[j*TAG_W +: TAG_W];
               end
            if (!rst) begin
               w_la = 1'b0;
               w_lt = '0;
            end
            if (p == 0) begin
               rs_alloc[k]              = w_la;
               rs_tag[k*TAG_W +: TAG_W] = w_lt;
            end else begin
               rt_alloc[k]              = w_la;
               rt_tag[k*TAG_W +: TAG_W] = w_lt;
            end
         end
      end
   end

   always_comb begin
      for (int a = 0; a < NUM_ARCH; a++) begin
         if (f_hit(AW'(a), r_al[a], r_tg[a], commit_valid, commit_arch, commit_tag)) begin
            w_nal[a] = 1'b0;
            w_ntg[a] = '0;
         end else begin
            w_nal[a] = r_al[a];
            w_ntg[a] = r_tg[a];
         end
         for (int i = 0; i < NUM_CKPT; i++) begin
            if (f_hit(AW'(a), r_cal[i][a], r_ctg[i][a], commit_valid, commit_arch, commit_tag)) begin
               w_cal[i][a] = 1'b0;
               w_ctg[i][a] = '0;
            end else begin
               w_cal[i][a] = r_cal[i][a];
               w_ctg[i][a] = r_ctg[i][a];
            end
         end
      end
      w_sal = w_nal;
      w_stg = w_ntg;
      // Later slots overwrite earlier ones; the snapshot stops at the branch's own slot.
      for (int j = 0; j < RENAME_W; j++)
         if (ren_valid[j]) begin
            w_nal[ren_dest[j*AW +: AW]] = 1'b1;
            w_ntg[ren_dest[j*AW +: AW]] = ren_tag[j*TAG_W +: TAG_W];
            if (j <= int'(ckpt_slot)) begin
               w_sal[ren_dest[j*AW +: AW]] = 1'b1;
               w_stg[ren_dest[j*AW +: AW]] = ren_tag[j*TAG_W +: TAG_W];
            end
         end
   end

   assign w_rdist   = restore_id - r_head;
   assign w_restore = restore_valid && ({1'b0, w_rdist} < r_count);
   assign w_release = ckpt_release && (r_count != '0);
   // A release in the same cycle frees the head slot, so a save at full still has room.
   assign w_save    = ckpt_save && (!ckpt_full || w_release);
   assign ckpt_full = (r_count == (CW+1)'(NUM_CKPT));
   assign ckpt_id   = r_tail;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst || flush) begin
         for (int a = 0; a < NUM_ARCH; a++) begin
            r_al[a] <= 1'b0;
            r_tg[a] <= '0;
            for (int i = 0; i < NUM_CKPT; i++) begin
               r_cal[i][a] <= 1'b0;
               r_ctg[i][a] <= '0;
            end
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (w_restore) begin
         for (int a = 0; a < NUM_ARCH; a++) begin
            r_al[a] <= w_cal[restore_id][a];
            r_tg[a] <= w_ctg[restore_id][a];
            for (int i = 0; i < NUM_CKPT; i++) begin
               r_cal[i][a] <= w_cal[i][a];
               r_ctg[i][a] <= w_ctg[i][a];
            end
         end
         r_tail  <= restore_id;
         r_count <= {1'b0, w_rdist};
      end else begin
         for (int a = 0; a < NUM_ARCH; a++) begin
            r_al[a] <= w_nal[a];
            r_tg[a] <= w_ntg[a];
            for (int i = 0; i < NUM_CKPT; i++) begin
               if (w_save && r_tail == CW'(i)) begin
                  r_cal[i][a] <= w_sal[a];
                  r_ctg[i][a] <= w_stg[a];
               end else begin
                  r_cal[i][a] <= w_cal[i][a];
                  r_ctg[i][a] <= w_ctg[i][a];
               end
            end
         end
         if (w_save) r_tail <= r_tail + 1'b1;
         if (w_release) r_head <= r_head + 1'b1;
         r_count <= r_count + (CW+1)'(w_save) - (CW+1)'(w_release);
      end
   end

endmodule
